// File: rtl/axi4_lite_traffic_master.sv
// AXI4-Lite initiator: xorshift64-driven write-then-readback pairs with readback checking.
// Latency: 4 cycles per pair against a zero-wait responder; valids hold until their handshake.
module axi4_lite_traffic_master #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int unsigned ADDR_WORDS = 16384,
    parameter int unsigned NUM_TRANS  = 256,
    parameter logic [63:0] SEED       = 64'd88172645463325252
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] error_count,
    output logic [31:0] first_err_addr
);
    localparam logic [31:0] WORD_MASK = 32'(ADDR_WORDS - 1);
    localparam logic [15:0] LAST_CNT  = 16'(NUM_TRANS);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA} state_t;

    function automatic logic [63:0] xs64(input logic [63:0] x);
        logic [63:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [63:0] r_s, w_s_nxt;
    logic [31:0] r_addr, w_addr_nxt, r_data, w_data_nxt;
    logic        r_awvalid, w_awvalid_nxt, r_wvalid, w_wvalid_nxt, r_bready, w_bready_nxt;
    logic        r_arvalid, w_arvalid_nxt, r_rready, w_rready_nxt;
    logic        r_busy, w_busy_nxt, r_done, w_done_nxt;
    logic [15:0] r_err_cnt, w_err_cnt_nxt, r_cnt, w_cnt_nxt;
    logic [31:0] r_first_err, w_first_err_nxt;
    logic [63:0] w_s_adv;
    logic [31:0] w_word;
    logic        w_launch;

    assign w_s_adv = xs64(r_s);
    assign w_word  = w_s_adv[33:2] & WORD_MASK;

    always_comb begin
        w_state_nxt     = r_state;
        w_s_nxt         = r_s;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_err_cnt_nxt   = r_err_cnt;
        w_cnt_nxt       = r_cnt;
        w_first_err_nxt = r_first_err;
        w_launch        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_done_nxt      = 1'b0;
                    w_err_cnt_nxt   = 16'd0;
                    w_first_err_nxt = 32'd0;
                    w_busy_nxt      = 1'b1;
                    w_cnt_nxt       = 16'd0;
                    w_launch        = 1'b1;
                end
            end
            S_WRITE: begin
                // AW and W complete independently; move on once neither is still pending
                w_awvalid_nxt = r_awvalid && !mem_axi_awready;
                w_wvalid_nxt  = r_wvalid && !mem_axi_wready;
                if (!w_awvalid_nxt && !w_wvalid_nxt) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (mem_axi_bvalid) begin
                    w_bready_nxt  = 1'b0;
                    w_arvalid_nxt = 1'b1;
                    w_state_nxt   = S_RADDR;
                end
            end
            S_RADDR: begin
                if (mem_axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (mem_axi_rvalid) begin
                    if (mem_axi_rdata != r_data) begin
                        if (r_err_cnt != 16'hFFFF) w_err_cnt_nxt = r_err_cnt + 16'd1;
                        if (r_err_cnt == 16'd0) w_first_err_nxt = r_addr;
                    end
                    w_cnt_nxt    = r_cnt + 16'd1;
                    w_rready_nxt = 1'b0;
                    if (w_cnt_nxt == LAST_CNT) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_launch = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_launch) begin
            w_s_nxt       = w_s_adv;
            w_addr_nxt    = ADDR_BASE + {w_word[29:0], 2'b00};
            w_data_nxt    = w_s_adv[63:32];
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = S_WRITE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_s         <= SEED;
            r_addr      <= 32'd0;
            r_data      <= 32'd0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_cnt   <= 16'd0;
            r_cnt       <= 16'd0;
            r_first_err <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_s         <= w_s_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_first_err <= w_first_err_nxt;
        end
    end

    assign mem_axi_awvalid = r_awvalid;
    assign mem_axi_awaddr  = r_addr;
    assign mem_axi_awprot  = 3'b000;
    assign mem_axi_wvalid  = r_wvalid;
    assign mem_axi_wdata   = r_data;
    assign mem_axi_wstrb   = 4'b1111;
    assign mem_axi_bready  = r_bready;
    assign mem_axi_arvalid = r_arvalid;
    assign mem_axi_araddr  = r_addr;
    assign mem_axi_arprot  = 3'b000;
    assign mem_axi_rready  = r_rready;
    assign busy            = r_busy;
    assign done            = r_done;
    assign error_count     = r_err_cnt;
    assign first_err_addr  = r_first_err;
endmodule

// File: tb/tb_axi4_lite_traffic_master.sv
// Bench for axi4_lite_traffic_master: configurable-delay responder with memory and
// an independent xorshift64 reference for addresses and data.
module tb_axi4_lite_traffic_master;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [63:0] SEED = 64'd88172645463325252;
    localparam int          NT   = 8;

    logic        clk = 1'b0;
    logic        resetn, start;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, busy, done;
    logic [31:0] awaddr, wdata, araddr, rdata, first_err_addr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [15:0] error_count;

    axi4_lite_traffic_master #(.ADDR_BASE(BASE), .ADDR_WORDS(256), .NUM_TRANS(NT), .SEED(SEED)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
        .mem_axi_awprot(awprot), .mem_axi_wvalid(wvalid), .mem_axi_wready(wready),
        .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb), .mem_axi_bvalid(bvalid),
        .mem_axi_bready(bready), .mem_axi_arvalid(arvalid), .mem_axi_arready(arready),
        .mem_axi_araddr(araddr), .mem_axi_arprot(arprot), .mem_axi_rvalid(rvalid),
        .mem_axi_rready(rready), .mem_axi_rdata(rdata), .busy(busy), .done(done),
        .error_count(error_count), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    // Responder controls, driven only by the stimulus process
    logic zw, rnd, corrupt;
    int   aw_fix, w_fix, ar_fix, ar_base;

    logic [31:0] mem [0:255];
    logic        r_awr, r_wr, r_arr, aw_got, w_got;
    logic [31:0] aw_q, w_q;
    int          aw_wait, w_wait, ar_wait, aw_rd, w_rd, ar_rd;
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        aw_fire, w_fire, ar_fire;
    int          aw_thr, w_thr, ar_thr;

    assign awready = zw | r_awr;
    assign wready  = zw | r_wr;
    assign arready = zw | r_arr;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;
    assign aw_thr  = rnd ? aw_rd : aw_fix;
    assign w_thr   = rnd ? w_rd : w_fix;
    assign ar_thr  = rnd ? ar_rd : ar_fix;

    function automatic logic [7:0] widx(input logic [31:0] a);
        logic [31:0] o;
        o = (a - BASE) >> 2;
        return o[7:0];
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            r_awr <= 1'b0; r_wr <= 1'b0; r_arr <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
            rdata <= 32'd0; aw_got <= 1'b0; w_got <= 1'b0; aw_q <= 32'd0; w_q <= 32'd0;
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; aw_rd <= 0; w_rd <= 0; ar_rd <= 0;
            aw_hs <= 0; w_hs <= 0; b_hs <= 0; ar_hs <= 0; r_hs <= 0;
        end else begin
            if (aw_fire) begin
                aw_hs <= aw_hs + 1; r_awr <= 1'b0; aw_wait <= 0; aw_rd <= $urandom_range(0, 3);
            end else if (awvalid) begin
                if (aw_wait >= aw_thr) r_awr <= 1'b1; else aw_wait <= aw_wait + 1;
            end
            if (w_fire) begin
                w_hs <= w_hs + 1; r_wr <= 1'b0; w_wait <= 0; w_rd <= $urandom_range(0, 3);
            end else if (wvalid) begin
                if (w_wait >= w_thr) r_wr <= 1'b1; else w_wait <= w_wait + 1;
            end
            if ((aw_got || aw_fire) && (w_got || w_fire)) begin
                mem[widx(aw_got ? aw_q : awaddr)] <= w_got ? w_q : wdata;
                bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_fire) begin aw_got <= 1'b1; aw_q <= awaddr; end
                if (w_fire) begin w_got <= 1'b1; w_q <= wdata; end
            end
            if (bvalid && bready) begin bvalid <= 1'b0; b_hs <= b_hs + 1; end
            if (ar_fire) begin
                ar_hs <= ar_hs + 1; r_arr <= 1'b0; ar_wait <= 0; ar_rd <= $urandom_range(0, 3);
                rvalid <= 1'b1;
                rdata  <= mem[widx(araddr)] ^
                          ((corrupt && (ar_hs - ar_base == 2 || ar_hs - ar_base == 6)) ? 32'h1 : 32'h0);
            end else if (arvalid) begin
                if (ar_wait >= ar_thr) r_arr <= 1'b1; else ar_wait <= ar_wait + 1;
            end
            if (rvalid && rready) begin rvalid <= 1'b0; r_hs <= r_hs + 1; end
        end
    end

    // Protocol monitor: valid/payload stability and write-response ordering
    logic        p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    int          stab_aw = 0, stab_w = 0, stab_ar = 0, order_viol = 0;
    logic [31:0] q_aw[$], q_w[$];

    always @(negedge clk) begin
        if (resetn && p_rst) begin
            if (p_awv && !p_awr && !(awvalid && awaddr == p_awaddr)) stab_aw <= stab_aw + 1;
            if (p_wv && !p_wr && !(wvalid && wdata == p_wdata)) stab_w <= stab_w + 1;
            if (p_arv && !p_arr && !(arvalid && araddr == p_araddr)) stab_ar <= stab_ar + 1;
        end
        if (bready && (aw_hs != b_hs + 1 || w_hs != b_hs + 1)) order_viol <= order_viol + 1;
        if (!resetn) begin
            q_aw.delete();
            q_w.delete();
        end else begin
            if (aw_fire) q_aw.push_back(awaddr);
            if (w_fire) q_w.push_back(wdata);
        end
        p_rst <= resetn; p_awv <= awvalid; p_awr <= awready; p_wv <= wvalid; p_wr <= wready;
        p_arv <= arvalid; p_arr <= arready; p_awaddr <= awaddr; p_wdata <= wdata; p_araddr <= araddr;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [63:0] m_s;
    logic [31:0] exp_addr [0:NT-1];

    function automatic logic [63:0] ref_next(input logic [63:0] x);
        logic [63:0] a, b;
        a = x ^ {x[50:0], 13'd0};
        b = a ^ {7'd0, a[63:7]};
        return b ^ {b[46:0], 17'd0};
    endfunction

    task automatic check_seq(input string tag);
        logic [31:0] a, d;
        for (int i = 0; i < NT; i++) begin
            m_s = ref_next(m_s);
            exp_addr[i] = BASE + ((m_s[33:2] & 32'h0000_00FF) << 2);
            a = (q_aw.size() > 0) ? q_aw.pop_front() : 32'hDEAD_DEAD;
            d = (q_w.size() > 0) ? q_w.pop_front() : 32'hDEAD_DEAD;
            chk({tag, "_awaddr"}, a, exp_addr[i]);
            chk({tag, "_wdata"}, d, m_s[63:32]);
        end
    endtask

    logic        s_done, s_busy;
    logic [15:0] s_err;
    logic [31:0] s_first;

    task automatic run(input int poke, output int lat);
        lat = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_done = done; s_busy = busy; s_err = error_count; s_first = first_err_addr;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
            start = (k == poke);
        end
        start = 1'b0;
        if (lat < 0) chk("run_timeout", 64'd0, 64'd1);
    endtask

    int          lat, b_aw, b_w, b_b, b_ar, b_r, waited;
    logic [31:0] first0;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; start = 1'b0; zw = 1'b1; rnd = 1'b0; corrupt = 1'b0;
        aw_fix = 0; w_fix = 0; ar_fix = 0; ar_base = 0; m_s = SEED;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("rst_busy_done", {busy, done}, 2'b00);
        chk("rst_err_cnt", error_count, 16'd0);
        chk("rst_first_err", first_err_addr, 32'd0);
        chk("rst_addr_data", {awaddr, araddr}, 64'd0);
        chk("rst_wdata", wdata, 32'd0);

        // Zero-wait responder: 4 cycles per pair
        b_aw = aw_hs; b_w = w_hs; b_b = b_hs; b_ar = ar_hs; b_r = r_hs;
        run(0, lat);
        chk("zw_latency", lat, 4 * NT);
        chk("zw_done_busy", {done, busy}, 2'b10);
        chk("zw_err_cnt", error_count, 16'd0);
        chk("zw_first_err", first_err_addr, 32'd0);
        chk("zw_hs_aw_w", {aw_hs - b_aw, w_hs - b_w}, {32'(NT), 32'(NT)});
        chk("zw_hs_b", b_hs - b_b, NT);
        chk("zw_hs_ar_r", {ar_hs - b_ar, r_hs - b_r}, {32'(NT), 32'(NT)});
        chk("const_prot_strb", {awprot, arprot, wstrb}, 10'h00F);
        check_seq("zw");
        first0 = exp_addr[0];

        // Skewed write channels, each direction
        zw = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            aw_fix = (pass == 0) ? 0 : 3;
            w_fix  = (pass == 0) ? 3 : 0;
            b_aw = aw_hs; b_w = w_hs;
            run(0, lat);
            chk("skew_hs_aw", aw_hs - b_aw, NT);
            chk("skew_hs_w", w_hs - b_w, NT);
            chk("skew_err_cnt", error_count, 16'd0);
            check_seq("skew");
        end
        chk("skew_order", order_viol, 0);

        // Randomised ready delays, 1000 transactions in total
        rnd = 1'b1;
        for (int r = 0; r < 125; r++) begin
            run(0, lat);
            chk("rnd_done", done, 1'b1);
            chk("rnd_err_cnt", error_count, 16'd0);
            check_seq("rnd");
        end
        chk("rnd_stable", {stab_aw, stab_w, stab_ar}, 96'd0);
        chk("rnd_order", order_viol, 0);

        // Corrupted 3rd and 7th readbacks
        rnd = 1'b0; zw = 1'b1; corrupt = 1'b1; ar_base = ar_hs;
        run(0, lat);
        corrupt = 1'b0;
        check_seq("cor");
        chk("cor_err_cnt", error_count, 16'd2);
        chk("cor_first_err", first_err_addr, exp_addr[2]);

        // Restart after done clears status; start while busy is ignored
        chk("pre_done", done, 1'b1);
        b_aw = aw_hs;
        run(5, lat);
        chk("restart_clear", {s_done, s_busy}, 2'b01);
        chk("restart_err_clear", s_err, 16'd0);
        chk("restart_first_clear", s_first, 32'd0);
        chk("busy_start_latency", lat, 4 * NT);
        chk("busy_start_hs", aw_hs - b_aw, NT);
        check_seq("cont");

        // Reset while a read address is outstanding
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waited = 0;
        while (!arvalid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("arvalid_seen", arvalid, 1'b1);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("midrst_busy_err", {busy, error_count}, 17'd0);
        resetn = 1'b1;
        m_s = SEED;
        run(0, lat);
        chk("midrst_done", done, 1'b1);
        check_seq("rerun");
        chk("rerun_from_seed", exp_addr[0], first0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4_lite_traffic_master.md
# axi4_lite_traffic_master

Synthesizable AXI4-Lite initiator used as the stimulus end of the bus. It drives write-then-readback transactions into any AXI4-Lite responder, such as the simulation memory model or a DUT slave, and checks every readback word. Addresses and data come from an internal xorshift64 generator. The block sits where the CPU's AXI port would, for standalone bus and memory-model soak tests, and reports pass/fail counters to the bench.

## Interface
Parameters:
- ADDR_BASE, 32'h0000_0000: byte base address of the test window.
- ADDR_WORDS, 16384: window size in 32-bit words; must be a power of two.
- NUM_TRANS, 256: write/readback pairs per run; range 1..65535.
- SEED, 64'd88172645463325252: xorshift64 initial state; must be nonzero.

Ports:
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a run
- mem_axi_awvalid/awready  out/in  1  write address handshake
- mem_axi_awaddr  out  32  write address
- mem_axi_awprot  out  3  constant 3'b000
- mem_axi_wvalid/wready  out/in  1  write data handshake
- mem_axi_wdata  out  32  write data
- mem_axi_wstrb  out  4  constant 4'b1111
- mem_axi_bvalid/bready  in/out  1  write response handshake
- mem_axi_arvalid/arready  out/in  1  read address handshake
- mem_axi_araddr  out  32  read address
- mem_axi_arprot  out  3  constant 3'b000 (data access)
- mem_axi_rvalid/rready  in/out  1  read data handshake
- mem_axi_rdata  in  32  read data
- busy  out  1  run in progress
- done  out  1  run finished; held until next accepted start or reset
- error_count  out  16  readback mismatches, saturating at 16'hFFFF
- first_err_addr  out  32  address of first mismatch; 0 if none

## Operation
- States: IDLE, WRITE, WRESP, RADDR, RDATA.
- Transaction launch (from IDLE on start, or from RDATA on a handshake with transactions remaining):
  - s <= xorshift64_next(s), with shifts <<13, >>7, <<17.
  - addr <= ADDR_BASE + {next[33:2] & (ADDR_WORDS-1), 2'b00}.
  - data <= next[63:32].
  - awvalid and wvalid are both set to 1.
- WRITE: awvalid and wvalid drop independently on their own handshakes, in either order or together. Enter WRESP when both are done. bready = 1 in WRESP.
- WRESP: on bvalid&&bready, drop bready, set arvalid=1 with araddr=addr, enter RADDR.
- RADDR: on arvalid&&arready, drop arvalid, set rready=1, enter RDATA.
- RDATA: on rvalid&&rready, compare rdata against the registered data.
  - On mismatch, error_count increments (saturating). first_err_addr is captured only if error_count was 0.
  - Transaction counter increments. If it reaches NUM_TRANS, drop rready, set done=1 and busy=0, and return to IDLE. Otherwise launch the next transaction in the same cycle.
- Accepting start in IDLE:
  - clears done, error_count and first_err_addr;
  - reloads nothing into s, so consecutive runs continue the sequence;
  - sets busy=1.
- start while busy is ignored.
- bresp and rresp are not present on the interface; responses are assumed OKAY.

## Timing
- Reset values:
  - all valid/ready outputs 0; busy 0, done 0, error_count 0, first_err_addr 0;
  - awaddr/araddr/wdata 0; s = SEED; state IDLE.
- All outputs are registered. Once a valid is asserted, it and its address/data stay stable until the handshake edge.
- start is sampled at edge S. awvalid/wvalid are high in the cycle following S.
- Against a responder with ready tied high and bvalid/rvalid registered one edge after the matching handshake, each transaction takes exactly 4 cycles. done rises 4*NUM_TRANS edges after S.
- A combinatorial same-cycle response (bvalid already high when WRESP is entered) completes in 1 cycle per phase. No minimum gap is enforced.
- resetn low at any edge, including mid-handshake, forces reset values on that edge. Partial transactions are abandoned and the responder is expected to be reset with it.

## Test plan
- Zero-wait model, NUM_TRANS=4, start at edge 10 -> done=1 at edge 26, error_count=0, 4 AW/W/B/AR/R handshakes; addresses and data match the bench xorshift reference model.
- Memory model in randomized-delay mode, NUM_TRANS=1000 -> all valids stable until ready (assertion checked every cycle), error_count=0, done asserted.
- Responder drives awready 3 cycles before wready, and separately wready before awready -> exactly one AW and one W handshake each, WRESP entered only after both.
- Responder XORs rdata with 32'h1 on 3rd and 7th reads -> error_count=2, first_err_addr = 3rd transaction address.
- resetn low for 1 cycle while arvalid=1 -> next cycle all valids 0, busy 0, error_count 0; a new start then re-runs from SEED.
- start pulsed during busy and again after done -> first ignored (counter unchanged); second clears done and error_count and continues the xorshift sequence.
